// File: rtl/usb_fs_host_tx.sv
// Full-speed USB host transmitter: serializes bytes into NRZI, bit-stuffed D+/D- line states
// framed by SYNC and EOP, with one USB bit lasting BIT_SAMPLES clock cycles.
module usb_fs_host_tx #(
    parameter int BIT_SAMPLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       underrun_o,
    output logic       busy_o,
    output logic       tx_en_o,
    output logic       dp_tx_o,
    output logic       dn_tx_o
);

    localparam int            CW       = $clog2(BIT_SAMPLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_SAMPLES - 1);
    localparam logic [7:0]    SYNC_PAT = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          cur_last_q, cur_last_d;
    logic          hold_valid_q, hold_valid_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic [2:0]    ones_q, ones_d;
    logic          dp_q, dp_d;
    logic          dn_q, dn_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic          ready_q, ready_d;

    logic          accept_s;
    logic          wrap_s;
    logic          emit_s;
    logic          emit_bit_s;
    logic [2:0]    next_idx_s;

    // Next-state, bit sequencing, NRZI and stuffing decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        cur_last_d   = cur_last_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        ones_d       = ones_q;
        dp_d         = dp_q;
        dn_d         = dn_q;
        en_d         = en_q;
        busy_d       = busy_q;
        underrun_d   = 1'b0;
        emit_s       = 1'b0;
        emit_bit_s   = 1'b0;
        accept_s     = tx_valid_i & ready_q;
        wrap_s       = (cnt_q == LAST_CNT);
        next_idx_s   = bit_idx_q + 3'd1;

        if (accept_s) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_data_i;
            hold_last_d  = tx_last_i;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (wrap_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q || accept_s) begin
                    state_d    = ST_SYNC;
                    busy_d     = 1'b1;
                    en_d       = 1'b1;
                    shift_d    = SYNC_PAT;
                    bit_idx_d  = 3'd0;
                    cur_last_d = 1'b0;
                    emit_s     = 1'b1;
                    emit_bit_s = SYNC_PAT[0];
                end else begin
                    en_d = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!wrap_s) begin
                    emit_s = 1'b0;
                end else if (ones_q == 3'd6) begin
                    // Six ones in a row: a stuffed zero precedes the next bit.
                    emit_s     = 1'b1;
                    emit_bit_s = 1'b0;
                end else if (bit_idx_q != 3'd7) begin
                    bit_idx_d  = next_idx_s;
                    emit_s     = 1'b1;
                    emit_bit_s = shift_q[next_idx_s];
                end else if (cur_last_q) begin
                    state_d   = ST_EOP_SE0;
                    bit_idx_d = 3'd0;
                    dp_d      = 1'b0;
                    dn_d      = 1'b0;
                end else if (hold_valid_q) begin
                    state_d      = ST_DATA;
                    shift_d      = hold_data_q;
                    cur_last_d   = hold_last_q;
                    hold_valid_d = 1'b0;
                    bit_idx_d    = 3'd0;
                    emit_s       = 1'b1;
                    emit_bit_s   = hold_data_q[0];
                end else begin
                    state_d    = ST_EOP_SE0;
                    underrun_d = 1'b1;
                    bit_idx_d  = 3'd0;
                    dp_d       = 1'b0;
                    dn_d       = 1'b0;
                end
            end
            ST_EOP_SE0: begin
                if (!wrap_s) begin
                    state_d = ST_EOP_SE0;
                end else if (bit_idx_q == 3'd1) begin
                    state_d = ST_EOP_J;
                    dp_d    = 1'b1;
                    dn_d    = 1'b0;
                end else begin
                    bit_idx_d = next_idx_s;
                end
            end
            ST_EOP_J: begin
                if (wrap_s) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_EOP_J;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                dp_d    = 1'b1;
                dn_d    = 1'b0;
            end
        endcase

        // NRZI: a zero toggles the line and restarts the run of ones.
        if (emit_s) begin
            if (emit_bit_s) begin
                ones_d = ones_q + 3'd1;
            end else begin
                ones_d = 3'd0;
                dp_d   = ~dp_q;
                dn_d   = ~dn_q;
            end
        end else begin
            ones_d = ones_d;
        end

        ready_d = ~hold_valid_d &
                  ((state_d == ST_IDLE) || (state_d == ST_SYNC) || (state_d == ST_DATA));
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            cur_last_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_last_q  <= 1'b0;
            ones_q       <= 3'd0;
            dp_q         <= 1'b1;
            dn_q         <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            ones_q       <= ones_d;
            dp_q         <= dp_d;
            dn_q         <= dn_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
            ready_q      <= ready_d;
        end
    end

    assign tx_ready_o = ready_q;
    assign underrun_o = underrun_q;
    assign busy_o     = busy_q;
    assign tx_en_o    = en_q;
    assign dp_tx_o    = dp_q;
    assign dn_tx_o    = dn_q;

endmodule

// File: doc/usb_fs_host_tx.md
Name: usb_fs_host_tx

Overview:
- Full-speed USB host-side packet transmitter for the verification bench.
- Serializes a byte stream into NRZI-encoded, bit-stuffed D+/D- line states: SYNC, then payload, then EOP.
- Drives the device's usb_p/usb_n through the bench's io_buf instances, producing stimulus for the usb_cdc receive path.
- Bit timing matches the device's oversampling: one USB bit = BIT_SAMPLES clk_i cycles.

Parameters:
- BIT_SAMPLES, 4, clk_i cycles per USB bit (≥2); clk_i = 12 MHz × BIT_SAMPLES.

Ports:
- clk_i  input  1  bench clock.
- rst_i  input  1  asynchronous active-high reset.
- tx_data_i  input  8  payload byte, LSB transmitted first.
- tx_last_i  input  1  marks the final byte of the packet; qualified by tx_valid_i.
- tx_valid_i  input  1  byte offered.
- tx_ready_o  output  1  holding register can accept a byte.
- underrun_o  output  1  one-cycle pulse: byte boundary reached with no byte available and no last seen.
- busy_o  output  1  high from packet start until EOP completes.
- tx_en_o  output  1  output-enable for D+/D- (bench io_buf in_not_out = ~tx_en_o).
- dp_tx_o  output  1  D+ drive value.
- dn_tx_o  output  1  D- drive value.

Behaviour:
- Reset values: dp_tx_o=1, dn_tx_o=0 (J), tx_en_o=0, busy_o=0, underrun_o=0, tx_ready_o=1. State is IDLE, holding register empty.
- Line states:
  - J = (1,0).
  - K = (0,1).
  - SE0 = (0,0).
  - NRZI: a 0 toggles J↔K; a 1 holds the line. The NRZI reference is J at packet start.
- Bit timing:
  - A sample counter runs 0..BIT_SAMPLES-1 while busy.
  - Line outputs change only when the counter wraps, so every bit is held exactly BIT_SAMPLES cycles.
- Holding register:
  - One byte plus last flag.
  - tx_ready_o = holding empty AND state ∈ {IDLE, SYNC, DATA}.
  - Transfer occurs on tx_valid_i & tx_ready_o.
  - In DATA, the shifter loads from the holding register when the current byte's final bit period (including any trailing stuff bit) ends; the holding register is freed on that load.
- States:
  - IDLE:
    - tx_en_o=0, lines J.
    - An accepted byte sets busy_o and moves to SYNC.
    - The next cycle has tx_en_o=1 and the first SYNC bit on the lines (K).
  - SYNC:
    - Sends 8'h80 LSB-first, giving K J K J K J K K.
    - After 8 bits: if the holding register is full, load it into the shifter and go to DATA.
    - If the holding register is empty, go to EOP_SE0 and pulse underrun_o.
  - DATA:
    - Sends 8 bits plus inserted stuff bits.
    - At a byte boundary, if the current byte had last set, go to EOP_SE0.
    - Otherwise, if the holding register is full, load it and continue.
    - Otherwise, pulse underrun_o and go to EOP_SE0.
  - EOP_SE0: SE0 for 2 bit times.
  - EOP_J: J for 1 bit time, then tx_en_o=0, busy_o=0, IDLE.
- Bit stuffing:
  - A ones-counter starts at 0 at SYNC start and counts SYNC bits as well.
  - After 6 consecutive 1s, a 0 is inserted (line toggles) before the next bit, and the counter clears.
  - A stuff bit due after the last data bit is still sent before EOP.
  - Every transmitted 0, real or stuffed, clears the counter.
- Bytes offered while in EOP_SE0/EOP_J are not accepted (tx_ready_o=0).
- Back-to-back packets: the earliest new SYNC starts 1 cycle after IDLE is re-entered.
- Reset mid-packet:
  - Outputs return to reset values immediately (asynchronous).
  - Holding register is discarded.
  - No EOP is sent.
- tx_valid_i and tx_last_i are sampled only on a transfer; tx_last_i on a non-transferred cycle is ignored.

Test Plan:
- BIT_SAMPLES=4, single byte 0xA5 with last → tx_en_o high for (8+8+3)×4=76 cycles.
  - Decoded lines: SYNC KJKJKJKK, then NRZI of bits 1,0,1,0,0,1,0,1, then SE0,SE0,J.
  - No stuffing; busy_o falls with tx_en_o.
- Single byte 0xFF with last → SYNC's trailing 1 plus 5 data 1s forces a stuff bit after data bit 4.
  - Total 17 bits before EOP; tx_en_o high for 80 cycles.
- Three bytes 0x01,0x02,0x03 (last on 0x03) with tx_valid_i held high → each byte accepted within the previous byte's transmission.
  - No gap between bytes; no underrun_o.
- Two bytes with tx_valid_i dropped after the first (no last) → underrun_o pulses once at the end of byte 1.
  - EOP follows immediately; returns to IDLE; tx_ready_o=1.
- Assert rst_i during byte 2 of a 4-byte packet → same cycle: tx_en_o=0 and lines J; tx_ready_o=1 after release.
  - A new packet 0x3C then transmits correctly from SYNC.
- Loopback bench: usb_fs_host_tx drives a SETUP token into the device → device receive path detects the packet and does not flag a bit-stuff error.
